// File: rtl/change_dispenser.sv
// change_dispenser
// Actuator-side back end of the vending machine. On a rising delivery level it
// latches the product choice and change code, runs the selected product motor
// for MOTOR_CYCLES cycles, then releases the owed Rs. 5 coins one at a time via
// an eject_req/eject_ack handshake. The Rs. 5 coin inventory is tracked here.
// An empty hopper, an ejector timeout or an illegal code latches a sticky
// fault that only reset clears.
//
// Ports
//   clk         system clock, posedge
//   reset       synchronous, active-high
//   delivery    dispense level from the vending FSM (rising edge triggers)
//   change      change code: 0000 none, 0101 Rs.5, 1010 Rs.10
//   choice      product select: 01 product 1, 10 product 2
//   refill      reload coin_count with COIN_INIT
//   eject_ack   ejector has released one coin
//   motor1/2    product motor drives
//   eject_req   request one Rs. 5 coin
//   busy        high outside IDLE and FAULT
//   done        one-cycle pulse at the end of a dispense
//   fault       sticky error flag
//   coin_count  Rs. 5 coins remaining
//   dstate      current state code
//
// state    | meaning
// IDLE     | waiting for a delivery rising edge
// MOTOR    | selected product motor on, down-counting MOTOR_CYCLES
// EJECT    | one-cycle gap; checks the hopper before each coin
// WAIT_ACK | eject_req high, down-counting ACK_TIMEOUT for eject_ack
// DONE     | one-cycle completion pulse
// FAULT    | sticky error, exit only by reset
module change_dispenser #(
    parameter int MOTOR_CYCLES = 8,
    parameter int COIN_INIT    = 15,
    parameter int ACK_TIMEOUT  = 16,
    parameter int CNT_W        = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             delivery,
    input  logic [3:0]       change,
    input  logic [1:0]       choice,
    input  logic             refill,
    input  logic             eject_ack,
    output logic             motor1,
    output logic             motor2,
    output logic             eject_req,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [CNT_W-1:0] coin_count,
    output logic [2:0]       dstate
);
    localparam int TMR_MAX = (MOTOR_CYCLES > ACK_TIMEOUT) ? MOTOR_CYCLES : ACK_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        MOTOR    = 3'b001,
        EJECT    = 3'b010,
        WAIT_ACK = 3'b011,
        DONE     = 3'b100,
        FAULT    = 3'b101
    } state_t;

    state_t           state, state_nxt;
    logic             delivery_d;
    logic             product, product_nxt;   // 0: product 1, 1: product 2
    logic [1:0]       owed, owed_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic             coin_take;
    logic             trigger;
    logic             choice_ok;
    logic             change_ok;
    logic [1:0]       change_owed;

    assign trigger = delivery & ~delivery_d;

    always_comb begin
        choice_ok   = (choice == 2'b01) || (choice == 2'b10);
        change_ok   = 1'b1;
        change_owed = 2'd0;
        case (change)
            4'b0000: change_owed = 2'd0;
            4'b0101: change_owed = 2'd1;
            4'b1010: change_owed = 2'd2;
            default: change_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        product_nxt = product;
        owed_nxt    = owed;
        tmr_nxt     = tmr;
        coin_take   = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    if (choice_ok && change_ok) begin
                        state_nxt   = MOTOR;
                        product_nxt = choice[1];
                        owed_nxt    = change_owed;
                        tmr_nxt     = TMR_W'(MOTOR_CYCLES - 1);
                    end else begin
                        state_nxt = FAULT;
                    end
                end
            end
            MOTOR: begin
                if (tmr == '0) state_nxt = (owed == 2'd0) ? DONE : EJECT;
                else           tmr_nxt   = tmr - TMR_W'(1);
            end
            EJECT: begin
                // Checking here means coin_count is never decremented from 0.
                if (coin_count == '0) begin
                    state_nxt = FAULT;
                end else begin
                    state_nxt = WAIT_ACK;
                    tmr_nxt   = TMR_W'(ACK_TIMEOUT - 1);
                end
            end
            WAIT_ACK: begin
                if (eject_ack) begin
                    coin_take = 1'b1;
                    owed_nxt  = owed - 2'd1;
                    state_nxt = (owed == 2'd1) ? DONE : EJECT;
                end else if (tmr == '0) begin
                    state_nxt = FAULT;
                end else begin
                    tmr_nxt = tmr - TMR_W'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            delivery_d <= 1'b0;
            product    <= 1'b0;
            owed       <= 2'd0;
            tmr        <= '0;
            coin_count <= CNT_W'(COIN_INIT);
        end else begin
            delivery_d <= delivery;
            product    <= product_nxt;
            owed       <= owed_nxt;
            tmr        <= tmr_nxt;
            // A refill wins over a coin released in the same cycle.
            if (refill)         coin_count <= CNT_W'(COIN_INIT);
            else if (coin_take) coin_count <= coin_count - CNT_W'(1);
        end
    end

    assign motor1    = (state == MOTOR) && !product;
    assign motor2    = (state == MOTOR) && product;
    assign eject_req = (state == WAIT_ACK);
    assign done      = (state == DONE);
    assign fault     = (state == FAULT);
    assign busy      = (state != IDLE) && (state != FAULT);
    assign dstate    = state;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
// Self-checking bench for change_dispenser: a vector table of single
// dispenses from reset, hand-written corner sequences, and a randomized run
// checked against a transaction-level model of the dispense rules.
module tb_change_dispenser;
    localparam int MOTOR_CYCLES = 8;
    localparam int COIN_INIT    = 15;
    localparam int ACK_TIMEOUT  = 16;
    localparam int CNT_W        = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic             delivery;
    logic [3:0]       change;
    logic [1:0]       choice;
    logic             refill;
    logic             eject_ack;
    logic             motor1, motor2, eject_req, busy, done, fault;
    logic [CNT_W-1:0] coin_count;
    logic [2:0]       dstate;

    int n_checks = 0;
    int n_pass   = 0;

    change_dispenser #(
        .MOTOR_CYCLES(MOTOR_CYCLES),
        .COIN_INIT   (COIN_INIT),
        .ACK_TIMEOUT (ACK_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .delivery  (delivery),
        .change    (change),
        .choice    (choice),
        .refill    (refill),
        .eject_ack (eject_ack),
        .motor1    (motor1),
        .motor2    (motor2),
        .eject_req (eject_req),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .coin_count(coin_count),
        .dstate    (dstate)
    );

    always #5 clk = ~clk;

    // Observed / expected summary of one dispense.
    typedef struct {
        int m1;
        int m2;
        int reqs;
        int req_cyc;
        int gap;
        int done_n;
        int busy_n;
        int first_motor;
        int fault;
        int coins;
    } obs_t;

    typedef struct {
        logic [1:0] ch;
        logic [3:0] cg;
        int         ack_dly;
        int         m1;
        int         m2;
        int         reqs;
        int         coins;
        int         fault;
        int         done_n;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1; delivery = 1'b0; eject_ack = 1'b0; refill = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_refill();
        @(negedge clk); refill = 1'b1;
        @(negedge clk); refill = 1'b0;
    endtask

    // Raise delivery once and observe until done/fault plus a short tail.
    // eject_ack is returned after ack_dly further cycles of eject_req high.
    task automatic run_txn(input logic [1:0] ch, input logic [3:0] cg,
                           input int ack_dly, input bit hold, output obs_t o);
        int req_run, low_run, extra;
        bit ended, seen_req;
        o = '{default: 0};
        req_run = 0; low_run = 0; extra = 0; ended = 0; seen_req = 0;
        choice = ch; change = cg;
        @(negedge clk); delivery = 1'b1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (!hold) delivery = 1'b0;
            if (motor1) o.m1++;
            if (motor2) o.m2++;
            if ((motor1 || motor2) && o.first_motor == 0) o.first_motor = cyc;
            if (busy) o.busy_n++;
            if (done) o.done_n++;
            if (eject_req) begin
                if (req_run == 0) begin
                    o.reqs++;
                    if (seen_req) o.gap = low_run;
                end
                req_run++; o.req_cyc++; seen_req = 1; low_run = 0;
            end else begin
                req_run = 0; low_run++;
            end
            eject_ack = eject_req && (req_run - 1 >= ack_dly);
            if (ended) extra++;
            else if (done || fault) ended = 1;
            if (extra == 3) break;
        end
        eject_ack = 1'b0;
        chk("txn_ended", int'(ended), 1);
        o.fault = int'(fault);
        o.coins = int'(coin_count);
    endtask

    // Transaction-level reference: what one delivery edge should produce.
    function automatic obs_t model(input logic [1:0] ch, input logic [3:0] cg,
                                   input int ack_dly, input int coins, input bit flt);
        obs_t e;
        int owed, reqlen;
        e = '{default: 0};
        e.coins = coins;
        e.fault = int'(flt);
        if (flt) return e;
        if (!(ch == 2'b01 || ch == 2'b10) || !(cg == 4'h0 || cg == 4'h5 || cg == 4'hA)) begin
            e.fault = 1;
            return e;
        end
        owed   = (cg == 4'h0) ? 0 : (cg == 4'h5) ? 1 : 2;
        reqlen = (ack_dly < ACK_TIMEOUT) ? ack_dly + 1 : ACK_TIMEOUT;
        if (ch == 2'b01) e.m1 = MOTOR_CYCLES; else e.m2 = MOTOR_CYCLES;
        e.first_motor = 1;
        e.busy_n = MOTOR_CYCLES;
        for (int i = 0; i < owed; i++) begin
            e.busy_n++;
            if (e.coins == 0) begin e.fault = 1; return e; end
            e.reqs++;
            e.req_cyc += reqlen;
            e.busy_n  += reqlen;
            if (ack_dly >= ACK_TIMEOUT) begin e.fault = 1; return e; end
            e.coins--;
        end
        e.gap = (e.reqs == 2) ? 1 : 0;
        e.busy_n++;
        e.done_n = 1;
        return e;
    endfunction

    task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
        chk({tag, ".m1"},          a.m1,          e.m1);
        chk({tag, ".m2"},          a.m2,          e.m2);
        chk({tag, ".reqs"},        a.reqs,        e.reqs);
        chk({tag, ".req_cyc"},     a.req_cyc,     e.req_cyc);
        chk({tag, ".gap"},         a.gap,         e.gap);
        chk({tag, ".done"},        a.done_n,      e.done_n);
        chk({tag, ".busy"},        a.busy_n,      e.busy_n);
        chk({tag, ".first_motor"}, a.first_motor, e.first_motor);
        chk({tag, ".fault"},       a.fault,       e.fault);
        chk({tag, ".coins"},       a.coins,       e.coins);
    endtask

    vec_t vecs[8];
    obs_t o, e;
    int   m_coins;
    bit   m_fault;
    int   mcnt;
    bit   found;

    initial begin
        reset = 1'b1; delivery = 1'b0; change = 4'h0; choice = 2'b00;
        refill = 1'b0; eject_ack = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst.motor1", int'(motor1), 0);
        chk("rst.motor2", int'(motor2), 0);
        chk("rst.eject_req", int'(eject_req), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.fault", int'(fault), 0);
        chk("rst.coin_count", int'(coin_count), COIN_INIT);
        chk("rst.dstate", int'(dstate), 0);
        reset = 1'b0;

        // Vector table: each entry is one dispense starting from reset.
        vecs[0] = '{2'b01, 4'h0, 0,  8, 0, 0, 15, 0, 1};
        vecs[1] = '{2'b10, 4'h5, 2,  0, 8, 1, 14, 0, 1};
        vecs[2] = '{2'b01, 4'hA, 1,  8, 0, 2, 13, 0, 1};
        vecs[3] = '{2'b10, 4'h5, 30, 0, 8, 1, 15, 1, 0};
        vecs[4] = '{2'b01, 4'h3, 0,  0, 0, 0, 15, 1, 0};
        vecs[5] = '{2'b11, 4'h0, 0,  0, 0, 0, 15, 1, 0};
        vecs[6] = '{2'b00, 4'h5, 0,  0, 0, 0, 15, 1, 0};
        vecs[7] = '{2'b10, 4'hA, 15, 0, 8, 2, 13, 0, 1};
        for (int i = 0; i < 8; i++) begin
            reset_dut();
            run_txn(vecs[i].ch, vecs[i].cg, vecs[i].ack_dly, 1'b0, o);
            chk($sformatf("vec%0d.m1", i),    o.m1,     vecs[i].m1);
            chk($sformatf("vec%0d.m2", i),    o.m2,     vecs[i].m2);
            chk($sformatf("vec%0d.reqs", i),  o.reqs,   vecs[i].reqs);
            chk($sformatf("vec%0d.coins", i), o.coins,  vecs[i].coins);
            chk($sformatf("vec%0d.fault", i), o.fault,  vecs[i].fault);
            chk($sformatf("vec%0d.done", i),  o.done_n, vecs[i].done_n);
        end

        // Ejector timeout: request held for exactly ACK_TIMEOUT cycles.
        reset_dut();
        run_txn(2'b01, 4'h5, 1000, 1'b0, o);
        chk("timeout.req_cyc", o.req_cyc, ACK_TIMEOUT);
        chk("timeout.fault", o.fault, 1);
        chk("timeout.coins", o.coins, COIN_INIT);

        // Two coins: one low cycle between requests; held level does not retrigger.
        reset_dut();
        run_txn(2'b01, 4'hA, 1, 1'b1, o);
        chk("two.reqs", o.reqs, 2);
        chk("two.gap", o.gap, 1);
        chk("two.coins", o.coins, 13);
        mcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (motor1 || motor2 || busy) mcnt++;
        end
        chk("held.no_retrigger", mcnt, 0);
        @(negedge clk); delivery = 1'b0;
        run_txn(2'b10, 4'h0, 0, 1'b0, o);
        chk("rerise.m2", o.m2, MOTOR_CYCLES);
        chk("rerise.done", o.done_n, 1);

        // Empty hopper, faults ignore deliveries, refill keeps fault.
        reset_dut();
        for (int i = 0; i < 7; i++) run_txn(2'b10, 4'hA, 0, 1'b0, o);
        chk("drain.coins", o.coins, 1);
        run_txn(2'b01, 4'h5, 0, 1'b0, o);
        chk("drain.last", o.coins, 0);
        run_txn(2'b01, 4'h5, 0, 1'b0, o);
        chk("empty.m1", o.m1, MOTOR_CYCLES);
        chk("empty.reqs", o.reqs, 0);
        chk("empty.fault", o.fault, 1);
        chk("empty.coins", o.coins, 0);
        run_txn(2'b10, 4'h0, 0, 1'b0, o);
        chk("fault_ignores.motor", o.m1 + o.m2, 0);
        chk("fault_ignores.busy", o.busy_n, 0);
        pulse_refill();
        chk("fault_refill.coins", int'(coin_count), COIN_INIT);
        chk("fault_refill.fault", int'(fault), 1);
        reset_dut();
        chk("fault_reset.fault", int'(fault), 0);
        chk("fault_reset.coins", int'(coin_count), COIN_INIT);

        // Reset in the middle of MOTOR.
        choice = 2'b01; change = 4'h5;
        @(negedge clk); delivery = 1'b1;
        @(negedge clk); delivery = 1'b0;
        repeat (2) @(negedge clk);
        chk("midrst.motor_before", int'(motor1), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst.motor1", int'(motor1), 0);
        chk("midrst.dstate", int'(dstate), 0);
        chk("midrst.busy", int'(busy), 0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrst.no_eject", int'(eject_req), 0);

        // Delivery held high across reset release triggers once.
        reset = 1'b1; delivery = 1'b1; choice = 2'b10; change = 4'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mcnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (motor2) mcnt++;
        end
        chk("held_reset.motor2", mcnt, MOTOR_CYCLES);
        delivery = 1'b0;

        // Refill coincident with an accepted ack.
        reset_dut();
        run_txn(2'b01, 4'hA, 0, 1'b0, o);
        chk("refack.pre_coins", o.coins, 13);
        choice = 2'b01; change = 4'h5;
        @(negedge clk); delivery = 1'b1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            delivery = 1'b0;
            if (eject_req) found = 1;
        end
        chk("refack.req_seen", int'(found), 1);
        eject_ack = 1'b1; refill = 1'b1;
        @(negedge clk);
        eject_ack = 1'b0; refill = 1'b0;
        chk("refack.coins", int'(coin_count), COIN_INIT);
        chk("refack.done", int'(done), 1);

        // Randomized dispenses against the transaction model.
        reset_dut();
        m_coins = COIN_INIT; m_fault = 0;
        for (int t = 0; t < 60; t++) begin
            logic [1:0] rch;
            logic [3:0] rcg;
            int         rdly;
            int         p;
            p = $urandom_range(0, 19);
            rch = (p == 0) ? 2'($urandom_range(0, 3)) : ($urandom_range(0, 1) ? 2'b01 : 2'b10);
            p = $urandom_range(0, 19);
            if (p == 0)      rcg = 4'($urandom_range(0, 15));
            else if (p < 7)  rcg = 4'h0;
            else if (p < 13) rcg = 4'h5;
            else             rcg = 4'hA;
            rdly = ($urandom_range(0, 24) == 0) ? 20 : $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) begin
                pulse_refill();
                m_coins = COIN_INIT;
            end
            e = model(rch, rcg, rdly, m_coins, m_fault);
            run_txn(rch, rcg, rdly, 1'b0, o);
            cmp_obs($sformatf("rnd%0d", t), o, e);
            m_coins = e.coins;
            m_fault = (e.fault != 0);
            if (m_fault) begin
                reset_dut();
                m_coins = COIN_INIT;
                m_fault = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
